genius_autoplayer: RTL and testbench
====================================

# genius_autoplayer

Automatic player for the Genius game, sitting on the opposite side of the game's display/button interface. It watches the sequence digit the game drives on its units 7-segment output and decodes each pattern back to a 2-bit symbol. It records the symbols in a small buffer, then replays them as timed one-hot button presses on the game's `btn` inputs. It is used for self-test on the board and as a bench driver in game-level simulation.

## Interface
Parameters:
- `DEPTH`, 16: buffer entries, which is the maximum sequence length.
- `PRESS_CYCLES`, 4: clock cycles each replayed button is held (≥1).
- `GAP_CYCLES`, 4: clock cycles with all buttons released after each press (≥1).

Ports:
- `clock`  in  1: single clock; all state on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: arms the player; low forces IDLE and clears the buffer.
- `seg_in`  in  7: observed digit pattern, segments a..g, active-high.
- `btn`  out  3: one-hot button drive; bit k = symbol k.
- `busy`  out  1: high in CAPTURE, PRESS, GAP.
- `count`  out  5: number of symbols currently captured (0..DEPTH).
- `err`  out  1: sticky; an invalid pattern was seen or the buffer overflowed.

## Operation
- Decode (combinational):
  - `7'b1111110` → symbol 0.
  - `7'b0110000` → symbol 1.
  - `7'b1101101` → symbol 2.
  - `7'b0000000` → blank.
  - Any other pattern → invalid.
- States: IDLE, CAPTURE, PRESS, GAP.
- IDLE:
  - A valid symbol with `enable`=1 writes buf[0], sets `count`=1, and moves to CAPTURE.
  - Blank and invalid patterns do not start capture; an invalid pattern sets `err`.
- CAPTURE:
  - Every cycle with a valid symbol writes buf[`count`] and increments `count`. Consecutive identical symbols are distinct entries, one per cycle.
  - An invalid pattern is not stored, sets `err`, and keeps the state.
  - A blank pattern loads the replay index with 0, sets `btn`=onehot(buf[0]), and moves to PRESS.
- Full: with `count`==DEPTH, further valid symbols are dropped, `err` is set, and `count` holds at DEPTH.
- PRESS:
  - Holds `btn` for PRESS_CYCLES cycles, then sets `btn`=0 and moves to GAP.
- GAP:
  - Holds `btn`=0 for GAP_CYCLES cycles.
  - If entries remain, increments the index, loads the next one-hot value, and moves to PRESS.
  - Otherwise sets `count`=0 and moves to IDLE.
- `seg_in` is ignored in PRESS and GAP.
- `enable` falling in any state: on the next edge, state=IDLE, `btn`=0, `count`=0, `err`=0.
- `err` clears only on reset or `enable`=0.

## Timing
- Reset values: state IDLE, `btn`=0, `busy`=0, `count`=0, `err`=0. Buffer contents are don't-care.
- All outputs are registered.
- A symbol sampled at edge N is reflected in `count` after edge N.
- Blank sampled at edge N puts `btn` high from edge N through edge N+PRESS_CYCLES.
- Each symbol occupies exactly PRESS_CYCLES+GAP_CYCLES cycles.
- Full replay of n symbols lasts n·(PRESS_CYCLES+GAP_CYCLES) cycles from the first press to IDLE.
- When a valid symbol and `count`==DEPTH coincide, the drop and `err` set happen on the same edge.
- Asynchronous reset mid-replay drops `btn` immediately, without waiting for a clock edge.

## Configuration
- `GENIUS_AUTOPLAYER_MISTAKE_EN`:
  - Defined: adds input port `inject_mistake` (1 bit), sampled on the CAPTURE→PRESS edge. If it is high, the last entry is replayed as (symbol+1) mod 3, letting the bench force a game loss.
  - Undefined: the port is absent and replay always matches capture exactly.

## Test plan
- Capture 2,1,0 on three consecutive cycles, then blank → `count`=3; `btn`=100,010,001, each for 4 cycles with 4-cycle gaps; then IDLE with `count`=0.
- Capture 1,1 (same symbol on two cycles), then blank → two separate 010 pulses.
- Capture 17 valid symbols → `count`=16, `err`=1; replay produces exactly 16 pulses.
- Drive `7'b1011011` in CAPTURE → `err`=1, `count` unchanged, capture continues.
- Deassert `enable` during the second PRESS → `btn`=000 next cycle, `count`=0, `busy`=0.
- With `GENIUS_AUTOPLAYER_MISTAKE_EN` defined and `inject_mistake`=1, capture 0,2 → replay 001 then 001 (the 2 becomes 0).

Source files
------------

// File: rtl/genius_autoplayer_if.sv
// genius_autoplayer_if: display/button bundle between the Genius game and the autoplayer.
// Optional inject_mistake is present only with GENIUS_AUTOPLAYER_MISTAKE_EN defined.
interface genius_autoplayer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  logic          enable;
  logic [6:0]    seg_in;
  logic [2:0]    btn;
  logic          busy;
  logic [CW-1:0] count;
  logic          err;
`ifdef GENIUS_AUTOPLAYER_MISTAKE_EN
  logic          inject_mistake;
  modport slave  (input enable, seg_in, inject_mistake, output btn, busy, count, err);
  modport master (output enable, seg_in, inject_mistake, input btn, busy, count, err);
`else
  modport slave  (input enable, seg_in, output btn, busy, count, err);
  modport master (output enable, seg_in, input btn, busy, count, err);
`endif
endinterface

// File: rtl/genius_autoplayer.sv
// genius_autoplayer: decodes the game's sequence digit, buffers symbols, replays them as timed button presses.
// GENIUS_AUTOPLAYER_MISTAKE_EN adds inject_mistake to corrupt the last replayed entry.
module genius_autoplayer #(
  parameter int DEPTH        = 16,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input logic               clock,
  input logic               reset,
  genius_autoplayer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2((PRESS_CYCLES > GAP_CYCLES ? PRESS_CYCLES : GAP_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, PRESS, GAP} state_t;
  state_t        r_state, w_state_nx;
  logic [1:0]    r_buf [DEPTH];
  logic [2:0]    r_btn, w_btn_nx;
  logic [CW-1:0] r_count, w_count_nx, w_nxt;
  logic [IW-1:0] r_idx, w_idx_nx;
  logic [TW-1:0] r_tmr, w_tmr_nx;
  logic          r_err, w_err_nx, r_mis, w_mis_nx;
  logic          w_wr, w_valid, w_blank, w_inj;
  logic [1:0]    w_sym;
  function automatic logic [2:0] onehot(input logic [1:0] s, input logic m);
    return 3'b001 << (m ? (s == 2'd2 ? 2'd0 : s + 2'd1) : s);
  endfunction
  always_comb begin
    w_sym   = bus.seg_in == 7'b0110000 ? 2'd1 : bus.seg_in == 7'b1101101 ? 2'd2 : 2'd0;
    w_valid = bus.seg_in inside {7'b1111110, 7'b0110000, 7'b1101101};
    w_blank = bus.seg_in == 7'b0000000;
  end
`ifdef GENIUS_AUTOPLAYER_MISTAKE_EN
  assign w_inj = bus.inject_mistake;
`else
  assign w_inj = 1'b0;
`endif
  assign w_nxt = CW'(r_idx) + CW'(1);
  always_comb begin
    w_state_nx = r_state;
    w_btn_nx   = r_btn;
    w_count_nx = r_count;
    w_err_nx   = r_err;
    w_idx_nx   = r_idx;
    w_tmr_nx   = r_tmr;
    w_mis_nx   = r_mis;
    w_wr       = 1'b0;
    if (!bus.enable) begin
      w_state_nx = IDLE;
      w_btn_nx   = '0;
      w_count_nx = '0;
      w_err_nx   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            w_wr       = 1'b1;
            w_count_nx = CW'(1);
            w_state_nx = CAPTURE;
          end else if (!w_blank) w_err_nx = 1'b1;
        end
        CAPTURE: begin
          if (w_valid) begin
            if (r_count == CW'(DEPTH)) w_err_nx = 1'b1;
            else begin
              w_wr       = 1'b1;
              w_count_nx = r_count + CW'(1);
            end
          end else if (w_blank) begin
            w_idx_nx   = '0;
            w_tmr_nx   = '0;
            w_mis_nx   = w_inj;
            w_btn_nx   = onehot(r_buf[0], w_inj && r_count == CW'(1));
            w_state_nx = PRESS;
          end else w_err_nx = 1'b1;
        end
        PRESS: begin
          w_tmr_nx = r_tmr + TW'(1);
          if (r_tmr == TW'(PRESS_CYCLES - 1)) begin
            w_tmr_nx   = '0;
            w_btn_nx   = '0;
            w_state_nx = GAP;
          end
        end
        GAP: begin
          w_tmr_nx = r_tmr + TW'(1);
          if (r_tmr == TW'(GAP_CYCLES - 1)) begin
            w_tmr_nx = '0;
            if (w_nxt == r_count) begin
              w_count_nx = '0;
              w_state_nx = IDLE;
            end else begin
              w_idx_nx   = w_nxt[IW-1:0];
              w_btn_nx   = onehot(r_buf[w_nxt[IW-1:0]], r_mis && w_nxt + CW'(1) == r_count);
              w_state_nx = PRESS;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_btn   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_tmr   <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_btn   <= w_btn_nx;
      r_count <= w_count_nx;
      r_err   <= w_err_nx;
      r_idx   <= w_idx_nx;
      r_tmr   <= w_tmr_nx;
      r_mis   <= w_mis_nx;
    end
  end
  // buffer contents need no reset; count alone says which entries are live
  always_ff @(posedge clock) begin
    if (w_wr) r_buf[r_state == IDLE ? '0 : r_count[IW-1:0]] <= w_sym;
  end
  assign bus.btn   = r_btn;
  assign bus.busy  = r_state != IDLE;
  assign bus.count = r_count;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_genius_autoplayer.sv
// tb_genius_autoplayer: table-driven decode vectors plus capture/replay sequences checked against a per-cycle btn scoreboard.
module tb_genius_autoplayer;
  localparam int P = 4, G = 4, D = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  genius_autoplayer_if #(.DEPTH(D)) bus();
  genius_autoplayer #(.DEPTH(D), .PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clock(clk), .reset(rst_n), .bus(bus)
  );
  typedef struct {
    logic [6:0] seg;
    int         count;
    int         err;
    int         busy;
    int         sym;
  } vec_t;
  vec_t       vecs [6];
  int         n_cmp = 0, n_fail = 0, mcount = 0;
  logic [2:0] exp_q [$];
  logic [6:0] seg_of [3] = '{7'b1111110, 7'b0110000, 7'b1101101};
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [6:0] s);
    bus.seg_in = s;
    cyc();
  endtask
  task automatic expect_sym(input int sym);
    if (mcount < D) begin
      mcount++;
      repeat (P) exp_q.push_back(3'b001 << sym);
      repeat (G) exp_q.push_back(3'b000);
    end
  endtask
  task automatic cap(input int sym);
    send(seg_of[sym]);
    expect_sym(sym);
  endtask
  task automatic clear();
    bus.enable = 1'b0;
    bus.seg_in = 7'b0;
    cyc();
    bus.enable = 1'b1;
    mcount = 0;
    exp_q.delete();
  endtask
  task automatic replay(input string name);
    send(7'b0);
    for (int t = 0; t < 4000 && bus.busy; t++) begin
      if (exp_q.size() == 0) begin
        check({name, "_overrun_busy"}, bus.busy, 0);
        break;
      end
      check({name, "_btn"}, bus.btn, exp_q.pop_front());
      cyc();
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_end_busy"}, bus.busy, 0);
    check({name, "_end_count"}, bus.count, 0);
    mcount = 0;
    exp_q.delete();
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.seg_in = 7'b0;
`ifdef GENIUS_AUTOPLAYER_MISTAKE_EN
    bus.inject_mistake = 1'b0;
`endif
    #12;
    check("rst_btn", bus.btn, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.count, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    cyc();
    vecs[0] = '{7'b1111110, 1, 0, 1, 0};
    vecs[1] = '{7'b0110000, 1, 0, 1, 1};
    vecs[2] = '{7'b1101101, 1, 0, 1, 2};
    vecs[3] = '{7'b0000000, 0, 0, 0, -1};
    vecs[4] = '{7'b1011011, 0, 1, 0, -1};
    vecs[5] = '{7'b1111111, 0, 1, 0, -1};
    foreach (vecs[i]) begin
      clear();
      send(vecs[i].seg);
      if (vecs[i].sym >= 0) expect_sym(vecs[i].sym);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].count);
      check($sformatf("vec%0d_err", i), bus.err, vecs[i].err);
      check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
      if (vecs[i].sym >= 0) replay($sformatf("vec%0d", i));
    end
    clear();
    cap(2); cap(1); cap(0);
    check("seq210_count", bus.count, 3);
    check("seq210_err", bus.err, 0);
    replay("seq210");
    clear();
    cap(1); cap(1);
    check("rep11_count", bus.count, 2);
    replay("rep11");
    clear();
    for (int i = 0; i < 17; i++) begin
      cap(i % 3);
      if (i == 15) begin
        check("full16_count", bus.count, 16);
        check("full16_err", bus.err, 0);
      end
    end
    check("full17_count", bus.count, 16);
    check("full17_err", bus.err, 1);
    replay("full");
    clear();
    cap(0);
    send(7'b1011011);
    check("inv_err", bus.err, 1);
    check("inv_count", bus.count, 1);
    check("inv_busy", bus.busy, 1);
    cap(2);
    check("inv_cont_count", bus.count, 2);
    check("inv_cont_err", bus.err, 1);
    replay("inv");
    clear();
    cap(2); cap(1); cap(0);
    send(7'b1011011);
    send(7'b0);
    repeat (9) cyc();
    check("drop_second_press_btn", bus.btn, 3'b010);
    bus.enable = 1'b0;
    cyc();
    check("drop_btn", bus.btn, 0);
    check("drop_count", bus.count, 0);
    check("drop_busy", bus.busy, 0);
    check("drop_err", bus.err, 0);
    clear();
    cap(1);
    send(7'b0);
    check("ares_pre_btn", bus.btn, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    check("ares_btn", bus.btn, 0);
    check("ares_busy", bus.busy, 0);
    check("ares_count", bus.count, 0);
    #2 rst_n = 1'b1;
    clear();
`ifdef GENIUS_AUTOPLAYER_MISTAKE_EN
    send(seg_of[0]);
    send(seg_of[2]);
    mcount = 0;
    expect_sym(0);
    expect_sym(0);
    bus.inject_mistake = 1'b1;
    replay("mistake");
    bus.inject_mistake = 1'b0;
    clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
